uart_rx_loader: RTL and testbench

//  Parametrised UART receiver that deserialises a byte stream on rxd and stores
//  it into an internal DEPTH-entry byte buffer for the core to read back. It

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_core.sv | 137 +++++++++++++
 rtl/uart_rx_loader.sv | 131 +++++++++++++
 tb/tb_uart_rx_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: receiver state encoding and parity modes.
// Pure declarations, no logic, no latency, no flow control.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_rx_core.sv
// UART frame receiver: synchroniser, baud counter, FSM and shift register; byte_vld pulses at the stop sample.
// Latency: 2 clk synchroniser plus mid-bit sampling; no backpressure, a started frame always runs to completion.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 2604,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = PAR_NONE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 start_en,
    output logic                 busy,
    output logic                 byte_vld,
    output logic [DATA_BITS-1:0] byte_dat,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             PAR_ODD_EXP = (PARITY == PAR_ODD);

    logic                 sync1_q;
    logic                 rxd_s_q;
    logic                 rxd_prev_q;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_wait_q, stop_wait_d;
    logic                 cnt_zero;
    logic                 fall;

    assign cnt_zero = (cnt_q == '0);
    assign fall     = rxd_prev_q & ~rxd_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            rxd_prev_q  <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            stop_wait_q <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            rxd_s_q     <= sync1_q;
            rxd_prev_q  <= rxd_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            stop_wait_q <= stop_wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        stop_wait_d = stop_wait_q;
        unique case (state_q)
            IDLE: begin
                if (fall && start_en) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxd_s_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    cnt_d   = CNT_FULL;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = STOP;
                    cnt_d   = CNT_FULL;
                end
            end
            STOP: begin
                // A low stop bit parks here until the line returns high.
                if (stop_wait_q) begin
                    if (rxd_s_q) begin
                        state_d     = IDLE;
                        stop_wait_d = 1'b0;
                    end
                end else if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxd_s_q) begin
                    state_d = IDLE;
                end else begin
                    stop_wait_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        byte_vld   = (state_q == STOP) && !stop_wait_q && cnt_zero && rxd_s_q;
        frame_err  = (state_q == STOP) && !stop_wait_q && cnt_zero && !rxd_s_q;
        parity_err = (state_q == uart_pkg::PARITY) && cnt_zero &&
                     ((rxd_s_q ^ (^shift_q)) != PAR_ODD_EXP);
        byte_dat   = shift_q;
    end

endmodule

// File: rtl/uart_rx_loader.sv
// UART loader: stores received bytes into a DEPTH-entry buffer until load_len bytes arrive; sticky error flags.
// Latency: buffer write and byte_valid one clk after the stop sample, rd_data one clk after rd_addr; no backpressure.
module uart_rx_loader
    import uart_pkg::*;
#(
    parameter int  CLK_PER_BIT = 2604,
    parameter int  DATA_BITS   = 8,
    parameter int  PARITY      = PAR_NONE,
    parameter int  DEPTH       = 1024,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 reading,
    input  logic [ADDR_W:0]      load_len,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 byte_valid,
    output logic [DATA_BITS-1:0] byte_data,
    output logic [ADDR_W:0]      byte_count,
    output logic                 busy,
    output logic                 finished,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic                 core_vld;
    logic [DATA_BITS-1:0] core_dat;
    logic                 core_ferr;
    logic                 core_perr;
    logic                 start_en;

    logic                 reading_prev_q;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 finished_q, finished_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 byte_valid_q, byte_valid_d;
    logic [DATA_BITS-1:0] byte_data_q, byte_data_d;
    logic [DATA_BITS-1:0] rd_data_q;
    logic [DATA_BITS-1:0] buf_mem [DEPTH];

    logic                 restart;
    logic [ADDR_W:0]      limit;
    logic                 wr_en;

    uart_rx_core #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .DATA_BITS   (DATA_BITS),
        .PARITY      (PARITY)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .start_en   (start_en),
        .busy       (busy),
        .byte_vld   (core_vld),
        .byte_dat   (core_dat),
        .frame_err  (core_ferr),
        .parity_err (core_perr)
    );

    always_comb begin
        restart  = reading & ~reading_prev_q;
        limit    = (load_len == '0) ? DEPTH_C : load_len;
        // Count compare also gates the cycle between the last write and finished rising.
        start_en = reading & ~finished_q & (count_q < limit);
        wr_en    = core_vld & (count_q < DEPTH_C);

        byte_valid_d = wr_en;
        byte_data_d  = wr_en ? core_dat : byte_data_q;

        count_d = count_q;
        if (restart) begin
            count_d = '0;
        end else if (wr_en) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end

        finished_d   = restart ? 1'b0 : (finished_q | (count_q >= limit));
        frame_err_d  = restart ? 1'b0 : (frame_err_q | core_ferr);
        parity_err_d = restart ? 1'b0 : (parity_err_q | core_perr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reading_prev_q <= 1'b0;
            count_q        <= '0;
            finished_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            parity_err_q   <= 1'b0;
            byte_valid_q   <= 1'b0;
            byte_data_q    <= '0;
        end else begin
            reading_prev_q <= reading;
            count_q        <= count_d;
            finished_q     <= finished_d;
            frame_err_q    <= frame_err_d;
            parity_err_q   <= parity_err_d;
            byte_valid_q   <= byte_valid_d;
            byte_data_q    <= byte_data_d;
        end
    end

    // Simple dual-port buffer; the registered read returns the pre-write contents on an address collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[count_q[ADDR_W-1:0]] <= core_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= buf_mem[rd_addr];
        end
    end

    assign rd_data    = rd_data_q;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign byte_count = count_q;
    assign finished   = finished_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Four receivers (8N1, 8E1, 7N1, 6O1) driven with directed and random frames and
// compared against a frame-level model of buffer contents, count and sticky flags.
module tb_uart_rx_loader;

    localparam int CPB = 16;
    localparam int DEP = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rxd;
    logic [3:0] reading;
    logic [4:0] load_len [4];
    logic [3:0] rd_addr  [4];

    wire [3:0]      byte_valid, busy, finished, frame_err, parity_err;
    wire [3:0][4:0] byte_count;
    wire [7:0]      rd0, rd1, bd0, bd1;
    wire [6:0]      rd2, bd2;
    wire [5:0]      rd3, bd3;

    int unsigned W  [4] = '{8, 8, 7, 6};
    int          PM [4] = '{0, 1, 0, 2};

    logic [7:0] exp_mem [4][DEP];
    int         exp_cnt [4];
    bit         exp_fin [4];
    bit         exp_ferr[4];
    bit         exp_perr[4];
    logic [7:0] exp_last[4];
    int         exp_vld [4];
    int         vcnt    [4];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    uart_rx_loader #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .DEPTH(DEP)) u_d0 (
        .clk(clk), .rst(rst), .rxd(rxd[0]), .reading(reading[0]), .load_len(load_len[0]),
        .rd_addr(rd_addr[0]), .rd_data(rd0), .byte_valid(byte_valid[0]), .byte_data(bd0),
        .byte_count(byte_count[0]), .busy(busy[0]), .finished(finished[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]));

    uart_rx_loader #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .DEPTH(DEP)) u_d1 (
        .clk(clk), .rst(rst), .rxd(rxd[1]), .reading(reading[1]), .load_len(load_len[1]),
        .rd_addr(rd_addr[1]), .rd_data(rd1), .byte_valid(byte_valid[1]), .byte_data(bd1),
        .byte_count(byte_count[1]), .busy(busy[1]), .finished(finished[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]));

    uart_rx_loader #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .DEPTH(DEP)) u_d2 (
        .clk(clk), .rst(rst), .rxd(rxd[2]), .reading(reading[2]), .load_len(load_len[2]),
        .rd_addr(rd_addr[2]), .rd_data(rd2), .byte_valid(byte_valid[2]), .byte_data(bd2),
        .byte_count(byte_count[2]), .busy(busy[2]), .finished(finished[2]),
        .frame_err(frame_err[2]), .parity_err(parity_err[2]));

    uart_rx_loader #(.CLK_PER_BIT(CPB), .DATA_BITS(6), .PARITY(2), .DEPTH(DEP)) u_d3 (
        .clk(clk), .rst(rst), .rxd(rxd[3]), .reading(reading[3]), .load_len(load_len[3]),
        .rd_addr(rd_addr[3]), .rd_data(rd3), .byte_valid(byte_valid[3]), .byte_data(bd3),
        .byte_count(byte_count[3]), .busy(busy[3]), .finished(finished[3]),
        .frame_err(frame_err[3]), .parity_err(parity_err[3]));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) vcnt[i] <= 0;
        end else begin
            for (int i = 0; i < 4; i++) if (byte_valid[i]) vcnt[i] <= vcnt[i] + 1;
        end
    end

    function automatic logic [7:0] rd_of(input int i);
        case (i)
            0:       return rd0;
            1:       return rd1;
            2:       return {1'b0, rd2};
            default: return {2'b0, rd3};
        endcase
    endfunction

    function automatic logic [7:0] bd_of(input int i);
        case (i)
            0:       return bd0;
            1:       return bd1;
            2:       return {1'b0, bd2};
            default: return {2'b0, bd3};
        endcase
    endfunction

    function automatic int lim(input int i);
        return (load_len[i] == 5'd0) ? DEP : int'(load_len[i]);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            exp_cnt[i] = 0; exp_fin[i] = 0; exp_ferr[i] = 0; exp_perr[i] = 0;
            exp_last[i] = 8'h00; exp_vld[i] = 0;
        end
    endtask

    task automatic model_restart(input int i);
        exp_cnt[i] = 0; exp_fin[i] = 0; exp_ferr[i] = 0; exp_perr[i] = 0;
    endtask

    task automatic send_bit(input int i, input bit b);
        rxd[i] = b;
        idle(CPB);
    endtask

    // Drives one frame; the model decides acceptance from the state at the start bit.
    task automatic send_frame(input int i, input logic [7:0] din, input bit stop_b,
                              input bit flip, input bit drop);
        bit         acc;
        logic [7:0] d;
        d   = din & (8'hFF >> (8 - W[i]));
        acc = reading[i] && !exp_fin[i] && (exp_cnt[i] < lim(i));
        send_bit(i, 1'b0);
        if (drop) reading[i] = 1'b0;
        for (int b = 0; b < int'(W[i]); b++) send_bit(i, d[b]);
        if (PM[i] != 0) send_bit(i, (^d) ^ (PM[i] == 2) ^ flip);
        send_bit(i, stop_b);
        rxd[i] = 1'b1;
        if (acc) begin
            if (PM[i] != 0 && flip) exp_perr[i] = 1;
            if (stop_b) begin
                exp_mem[i][exp_cnt[i]] = d;
                exp_cnt[i]++;
                exp_last[i] = d;
                exp_vld[i]++;
                if (exp_cnt[i] >= lim(i)) exp_fin[i] = 1;
            end else begin
                exp_ferr[i] = 1;
            end
        end
    endtask

    task automatic check_state(input int i);
        check($sformatf("count%0d", i),  byte_count[i], exp_cnt[i]);
        check($sformatf("fin%0d", i),    finished[i],   exp_fin[i]);
        check($sformatf("ferr%0d", i),   frame_err[i],  exp_ferr[i]);
        check($sformatf("perr%0d", i),   parity_err[i], exp_perr[i]);
        check($sformatf("vpulse%0d", i), vcnt[i],       exp_vld[i]);
        check($sformatf("bdata%0d", i),  bd_of(i),      exp_last[i]);
        check($sformatf("busy%0d", i),   busy[i],       1'b0);
    endtask

    task automatic read_check(input int i, input int a, input logic [7:0] want);
        rd_addr[i] = a[3:0];
        idle(1);
        check($sformatf("rd%0d[%0d]", i, a), rd_of(i), want);
    endtask

    task automatic restart(input int i, input logic [4:0] len);
        reading[i]  = 1'b0;
        load_len[i] = len;
        idle(2);
        reading[i] = 1'b1;
        idle(2);
        model_restart(i);
    endtask

    initial begin
        #3_000_000;
        errors++;
        checks++;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        rst     = 1'b1;
        rxd     = '1;
        reading = '1;
        for (int i = 0; i < 4; i++) begin
            load_len[i] = 5'd0;
            rd_addr[i]  = 4'd0;
        end
        model_reset();
        idle(3);
        for (int i = 0; i < 4; i++) begin
            check_state(i);
            check($sformatf("rst_rd%0d", i), rd_of(i), 8'h00);
        end
        rst = 1'b0;
        idle(4);

        // Reset during the data bits of 0xA5, then a clean 0xA5.
        send_bit(0, 1'b0); send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b1);
        check("busy_mid", busy[0], 1'b1);
        rst    = 1'b1;
        rxd[0] = 1'b1;
        idle(2);
        model_reset();
        check_state(0);
        check("rst_mid_rd", rd_of(0), 8'h00);
        rst = 1'b0;
        idle(4);
        send_frame(0, 8'hA5, 1, 0, 0); idle(20);
        check_state(0);
        read_check(0, 0, 8'hA5);

        // load_len = 2: two frames finish the load, the third is ignored.
        restart(0, 5'd2);
        send_frame(0, 8'h55, 1, 0, 0); idle(20);
        send_frame(0, 8'hAA, 1, 0, 0); idle(20);
        check_state(0);
        read_check(0, 0, 8'h55);
        read_check(0, 1, 8'hAA);
        send_frame(0, 8'h33, 1, 0, 0); idle(20);
        check_state(0);

        // Short low glitch on an idle line.
        restart(0, 5'd0);
        rxd[0] = 1'b0; idle(CPB / 4); rxd[0] = 1'b1;
        idle(1);
        check("glitch_busy_on", busy[0], 1'b1);
        idle(9);
        check("glitch_busy_off", busy[0], 1'b0);
        idle(10);
        check_state(0);

        // Framing error, then a good frame lands at address 0.
        send_frame(0, 8'h3C, 0, 0, 0); idle(20);
        check_state(0);
        send_frame(0, 8'h81, 1, 0, 0); idle(20);
        check_state(0);
        read_check(0, 0, 8'h81);

        // reading dropped mid-frame: frame completes, next one ignored.
        send_frame(0, 8'h5A, 1, 0, 1); idle(20);
        check_state(0);
        read_check(0, 1, 8'h5A);
        send_frame(0, 8'h11, 1, 0, 0); idle(20);
        check_state(0);
        reading[0] = 1'b1;
        idle(2);
        model_restart(0);
        check_state(0);

        // Even parity: good random frames, then 0x07 with parity bit 0.
        for (int k = 0; k < 4; k++) begin
            send_frame(1, 8'($urandom), 1, 0, 0); idle(20);
            check_state(1);
        end
        send_frame(1, 8'h07, 1, 1, 0); idle(20);
        check_state(1);
        for (int a = 0; a < exp_cnt[1]; a++) read_check(1, a, exp_mem[1][a]);

        // Odd parity, 6 data bits, random parity and stop faults.
        for (int k = 0; k < 8; k++) begin
            send_frame(3, 8'($urandom), ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0), 0);
            idle(20);
            check_state(3);
        end
        for (int a = 0; a < exp_cnt[3]; a++) read_check(3, a, exp_mem[3][a]);

        // 7 data bits: back-to-back frames, a framing error, then restart clears.
        send_frame(2, 8'h7F, 1, 0, 0);
        send_frame(2, 8'h00, 1, 0, 0); idle(20);
        check_state(2);
        read_check(2, 0, 8'h7F);
        read_check(2, 1, 8'h00);
        send_frame(2, 8'h15, 0, 0, 0); idle(20);
        check_state(2);
        restart(2, 5'd0);
        check_state(2);

        // Fill all DEPTH entries; the extra frame must not wrap onto address 0.
        for (int k = 0; k < DEP + 1; k++) begin
            send_frame(2, 8'($urandom), 1, 0, 0); idle(20);
        end
        check_state(2);
        for (int a = 0; a < DEP; a++) read_check(2, a, exp_mem[2][a]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
